// File: rtl/dc_psq_pkg.sv
// Shared types and helpers for the Q-bus power/restart sequencer.
package dc_psq_pkg;

  typedef enum logic [2:0] {
    S_OFF   = 3'd0,
    S_DCUP  = 3'd1,
    S_ACUP  = 3'd2,
    S_RUN   = 3'd3,
    S_RWAIT = 3'd4,
    S_RHOLD = 3'd5,
    S_PFDN  = 3'd6
  } psq_state_e;

  // Bits needed to hold values 0..v-1; never less than 1 so counters stay legal.
  function automatic int clog2(input int unsigned v);
    int r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/dc_filt.sv
// Two-flop synchronizer followed by a consecutive-sample glitch filter.
module dc_filt
  import dc_psq_pkg::*;
#(
  parameter int FLT_CLK = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  localparam int CW = clog2(FLT_CLK + 1);

  logic          s1_q, s2_q;
  logic          q_q, q_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Output only flips after FLT_CLK consecutive disagreeing samples.
  always_comb begin
    q_d   = q_q;
    cnt_d = '0;
    if (s2_q != q_q) begin
      if (cnt_q == CW'(FLT_CLK - 1)) begin
        q_d   = s2_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Synchronizer, filter count and filtered level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      q_q   <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q  <= d;
      s2_q  <= s1_q;
      q_q   <= q_d;
      cnt_q <= cnt_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/dc_psq.sv
// Q-bus power/restart sequencer: drives DCLO/ACLO from filtered power-good
// and restart requests, using dc_pulse (via trig_a_n/trig_b) as the restart hold.
module dc_psq
  import dc_psq_pkg::*;
#(
  parameter int FLT_CLK  = 16,
  parameter int DCUP_CLK = 3000,
  parameter int ACUP_CLK = 7000,
  parameter int PFDN_CLK = 4000,
  parameter int OFF_CLK  = 100,
  parameter int PTMO_CLK = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic pwr_in,
  input  logic rst_req,
  input  logic pulse_q,
  output logic trig_a_n,
  output logic trig_b,
  output logic dclo,
  output logic aclo,
  output logic run,
  output logic fault
);

  localparam int M1    = (DCUP_CLK > ACUP_CLK) ? DCUP_CLK : ACUP_CLK;
  localparam int M2    = (PFDN_CLK > OFF_CLK)  ? PFDN_CLK : OFF_CLK;
  localparam int M3    = (M1 > M2) ? M1 : M2;
  localparam int MAXC  = (M3 > PTMO_CLK) ? M3 : PTMO_CLK;
  localparam int CNT_W = clog2(MAXC + 1);

  logic               pwr_ok;
  psq_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               fire_q, fire_d;
  logic               fault_q, fault_d;
  logic               dclo_q, dclo_d;
  logic               aclo_q, aclo_d;
  logic               rst_prev_q;

  dc_filt #(.FLT_CLK(FLT_CLK)) u_filt (
    .clk  (clk),
    .reset(reset),
    .d    (pwr_in),
    .q    (pwr_ok)
  );

  // Next state, shared counter load/decrement, trigger and sticky fault.
  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;
    fire_d  = 1'b0;
    fault_d = fault_q;
    unique case (state_q)
      S_OFF: begin
        if (cnt_q == '0 && pwr_ok) begin
          state_d = S_DCUP;  cnt_d = CNT_W'(DCUP_CLK);
        end
      end
      S_DCUP: begin
        if (!pwr_ok) begin
          state_d = S_OFF;   cnt_d = CNT_W'(OFF_CLK);
        end else if (cnt_q == '0) begin
          state_d = S_ACUP;  cnt_d = CNT_W'(ACUP_CLK);
        end
      end
      S_ACUP: begin
        if (!pwr_ok) begin
          state_d = S_PFDN;  cnt_d = CNT_W'(PFDN_CLK);
        end else if (cnt_q == '0) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (!pwr_ok) begin
          state_d = S_PFDN;  cnt_d = CNT_W'(PFDN_CLK);
        end else if (rst_req && !rst_prev_q) begin
          state_d = S_RWAIT; cnt_d = CNT_W'(PTMO_CLK);
          fire_d  = 1'b1;
        end
      end
      S_RWAIT: begin
        if (!pwr_ok) begin
          state_d = S_OFF;   cnt_d = CNT_W'(OFF_CLK);
        end else if (pulse_q) begin
          state_d = S_RHOLD;
        end else if (cnt_q == '0) begin
          // dc_pulse never answered: flag it and retry the power-up ramp.
          fault_d = 1'b1;
          state_d = S_DCUP;  cnt_d = CNT_W'(DCUP_CLK);
        end
      end
      S_RHOLD: begin
        if (!pwr_ok) begin
          state_d = S_OFF;   cnt_d = CNT_W'(OFF_CLK);
        end else if (!pulse_q) begin
          state_d = S_DCUP;  cnt_d = CNT_W'(DCUP_CLK);
        end
      end
      S_PFDN: begin
        // Power coming back here is ignored; the shutdown always completes.
        if (cnt_q == '0) begin
          state_d = S_OFF;   cnt_d = CNT_W'(OFF_CLK);
        end
      end
      default: begin
        state_d = S_OFF;     cnt_d = CNT_W'(OFF_CLK);
      end
    endcase
    if (state_d == S_OFF && state_q != S_OFF) fault_d = 1'b0;
    // Bus lines decoded from the next state so they move with the state.
    dclo_d = (state_d == S_OFF) || (state_d == S_DCUP) ||
             (state_d == S_RWAIT) || (state_d == S_RHOLD);
    aclo_d = (state_d != S_RUN);
  end

  // State, counter, trigger and registered bus outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_OFF;
      cnt_q      <= '0;
      fire_q     <= 1'b0;
      fault_q    <= 1'b0;
      dclo_q     <= 1'b1;
      aclo_q     <= 1'b1;
      rst_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      fire_q     <= fire_d;
      fault_q    <= fault_d;
      dclo_q     <= dclo_d;
      aclo_q     <= aclo_d;
      rst_prev_q <= rst_req;
    end
  end

  assign trig_a_n = ~fire_q;
  assign trig_b   = fire_q;
  assign dclo     = dclo_q;
  assign aclo     = aclo_q;
  assign run      = (state_q == S_RUN);
  assign fault    = fault_q;

endmodule

// File: tb/tb_dc_psq.sv
// Scoreboard bench for dc_psq: expected output-change events are queued as
// stimulus is applied and matched (cycle + value) whenever outputs change.
module tb_dc_psq;

  localparam int FLT = 4, DCUP = 10, ACUP = 20, PFDN = 30, OFFC = 5, PTMO = 8;
  localparam int PW  = 50;

  // {dclo, aclo, run, fault, trig_b, trig_a_n}
  localparam logic [5:0] V_OFF  = 6'b110001;
  localparam logic [5:0] V_ACUP = 6'b010001;
  localparam logic [5:0] V_RUN  = 6'b001001;
  localparam logic [5:0] V_FIRE = 6'b110010;
  localparam logic [5:0] V_FLT  = 6'b000100;

  logic clk, reset, pwr_in, rst_req, pulse_q;
  logic trig_a_n, trig_b, dclo, aclo, run, fault;
  logic [5:0] vec, prev;

  typedef struct { int cyc; logic [5:0] val; } ev_t;
  ev_t sbq[$];

  int n_cmp, n_bad, cyc, pcnt;
  bit mon_en, pmode;

  dc_psq #(.FLT_CLK(FLT), .DCUP_CLK(DCUP), .ACUP_CLK(ACUP), .PFDN_CLK(PFDN),
           .OFF_CLK(OFFC), .PTMO_CLK(PTMO)) dut (
    .clk(clk), .reset(reset), .pwr_in(pwr_in), .rst_req(rst_req),
    .pulse_q(pulse_q), .trig_a_n(trig_a_n), .trig_b(trig_b),
    .dclo(dclo), .aclo(aclo), .run(run), .fault(fault)
  );

  assign vec = {dclo, aclo, run, fault, trig_b, trig_a_n};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push(input int at, input logic [5:0] v);
    ev_t e;
    e.cyc = at; e.val = v;
    sbq.push_back(e);
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Behavioural dc_pulse: q high for PW clocks after a trig_b strobe.
  always @(negedge clk) begin
    if (pmode && trig_b) pcnt = PW;
    else if (pcnt > 0)   pcnt = pcnt - 1;
    pulse_q = (pcnt > 0);
  end

  // Output-change monitor: every change must match the head of the queue.
  always @(negedge clk) begin
    if (mon_en && vec != prev) begin
      if (sbq.size() == 0) begin
        chk("unexp_evt", int'(vec), int'(prev));
      end else begin
        ev_t e;
        e = sbq.pop_front();
        chk("evt_cyc", cyc, e.cyc);
        chk("evt_val", int'(vec), int'(e.val));
      end
      chk("aclo_dclo_order", int'(aclo || !dclo), 1);
      prev = vec;
    end
  end

  initial begin
    int c0, r, t, p, q0, p2;
    n_cmp = 0; n_bad = 0; cyc = 0; pcnt = 0;
    mon_en = 0; pmode = 0;
    reset = 1'b1; pwr_in = 1'b0; rst_req = 1'b0; pulse_q = 1'b0;
    #1;
    chk("rst_dclo", dclo, 1);
    chk("rst_aclo", aclo, 1);
    chk("rst_run", run, 0);
    chk("rst_fault", fault, 0);
    chk("rst_trig_b", trig_b, 0);
    chk("rst_trig_a_n", trig_a_n, 1);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    prev = vec;
    mon_en = 1;
    wait_to(cyc + 5);

    // 3-clock glitch must be swallowed by the filter.
    c0 = cyc;
    pwr_in = 1'b1;
    wait_to(c0 + 3);
    pwr_in = 1'b0;
    wait_to(c0 + 12);
    chk("glitch3_pwr_ok", dut.pwr_ok, 0);

    // Power-up: sync 2 + filter 4, OFF->DCUP, DCUP+1, ACUP+1.
    c0 = cyc;
    pwr_in = 1'b1;
    push(c0 + 18, V_ACUP);
    push(c0 + 39, V_RUN);
    wait_to(c0 + 5);
    chk("pwr_ok_pre", dut.pwr_ok, 0);
    wait_to(c0 + 6);
    chk("pwr_ok_rise", dut.pwr_ok, 1);
    wait_to(c0 + 45);
    chk("run_up", run, 1);

    // Restart through dc_pulse; rst_req held high must not re-trigger.
    r = cyc;
    pmode = 1;
    rst_req = 1'b1;
    push(r + 1, V_FIRE);
    push(r + 2, V_OFF);
    push(r + 63, V_ACUP);
    push(r + 84, V_RUN);
    wait_to(r + 30);
    chk("hold_dclo", dclo, 1);
    wait_to(r + 95);
    rst_req = 1'b0;
    wait_to(r + 98);

    // Timeout: dc_pulse never answers.
    pmode = 0;
    t = cyc;
    rst_req = 1'b1;
    push(t + 1, V_FIRE);
    push(t + 2, V_OFF);
    push(t + 10, V_OFF | V_FLT);
    push(t + 21, V_ACUP | V_FLT);
    push(t + 42, V_RUN | V_FLT);
    wait_to(t + 9);
    chk("tmo_fault_pre", fault, 0);
    wait_to(t + 10);
    chk("tmo_fault", fault, 1);
    wait_to(t + 50);
    rst_req = 1'b0;

    // Power fail from RUN; power returns mid-PFDN but shutdown completes.
    p = cyc;
    pwr_in = 1'b0;
    push(p + 7, V_ACUP | V_FLT);
    push(p + 38, V_OFF);
    push(p + 55, V_ACUP);
    wait_to(p + 15);
    pwr_in = 1'b1;
    wait_to(p + 60);

    // Asynchronous reset in ACUP.
    chk("sb_pre_rst", sbq.size(), 0);
    mon_en = 0;
    #2 reset = 1'b1;
    #1;
    chk("arst_dclo", dclo, 1);
    chk("arst_aclo", aclo, 1);
    chk("arst_trig_b", trig_b, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    q0 = cyc;
    prev = vec;
    mon_en = 1;
    push(q0 + 18, V_ACUP);
    push(q0 + 39, V_RUN);
    wait_to(q0 + 45);

    // Power fail with power staying off: no re-power-up after OFF hold.
    p2 = cyc;
    pwr_in = 1'b0;
    push(p2 + 7, V_ACUP);
    push(p2 + 38, V_OFF);
    wait_to(p2 + 80);
    chk("stay_off_dclo", dclo, 1);
    chk("stay_off_run", run, 0);

    chk("sb_drain", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dc_psq.md
Name: dc_psq

Overview:
- Q-bus power/restart sequencer for the F11 board; drives the bus DCLO/ACLO lines from a raw power-good level and a restart request.
- It is the stage directly upstream of the dc_pulse monostable.
- For restarts it fires dc_pulse through that block's a_n/b inputs and consumes its q output as the DCLO hold interval.
- Power-up and power-down timing are handled by internal counters.

Parameters:
- FLT_CLK, 16: glitch-filter length on pwr_in, in clocks.
- DCUP_CLK, 3000: clocks from stable power-good to DCLO negation.
- ACUP_CLK, 7000: clocks from DCLO negation to ACLO negation.
- PFDN_CLK, 4000: clocks from ACLO assertion to DCLO assertion on power fail.
- OFF_CLK, 100: minimum clocks DCLO/ACLO stay asserted in OFF before a new power-up.
- PTMO_CLK, 8: clocks allowed for pulse_q to rise after a trigger.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- pwr_in  in  1  raw power-good level, asynchronous to clk
- rst_req  in  1  restart request, synchronous, level; acted on at its rising edge
- pulse_q  in  1  q output of dc_pulse
- trig_a_n  out  1  to dc_pulse a_n; active-low trigger
- trig_b  out  1  to dc_pulse b; active-high trigger
- dclo  out  1  DC-low to bus, 1 = asserted
- aclo  out  1  AC-low to bus, 1 = asserted
- run  out  1  1 only in state RUN
- fault  out  1  sticky; set when a pulse timeout occurs, cleared by reset or on entry to OFF

Behaviour:
- Reset (asynchronous, active-high):
  - state=OFF; dclo=1, aclo=1, run=0, fault=0.
  - trig_a_n=1, trig_b=0.
  - All counters 0; synchronizer and filter cleared to 0.
- pwr_in conditioning:
  - Two-flop synchronizer, then filter.
  - pwr_ok changes only after the synchronized value differs from pwr_ok for FLT_CLK consecutive clocks.
  - Any return to the old value restarts the filter count.
- Trigger outputs:
  - trig_a_n=~fire and trig_b=fire, where fire is registered and high for exactly one clock.
  - Between fires, trig_b returns low, so dc_pulse sees a fresh start edge.
- Counters:
  - A single shared down-counter, wide enough for the largest parameter (clog2 of the maximum, computed by a function).
  - Loaded on state entry; the state advances in the clock after the counter reads 0.
- States and transitions:
  - OFF (dclo=1, aclo=1): count OFF_CLK; then, if pwr_ok=1, go to DCUP.
  - DCUP (dclo=1, aclo=1): count DCUP_CLK, then go to ACUP.
  - ACUP (dclo=0, aclo=1): count ACUP_CLK, then go to RUN.
  - RUN (dclo=0, aclo=0, run=1): a rising edge of rst_req fires and goes to RWAIT.
  - RWAIT (dclo=1, aclo=1): wait for pulse_q=1, then go to RHOLD. If PTMO_CLK clocks elapse with pulse_q=0, set fault and go to DCUP.
  - RHOLD (dclo=1, aclo=1): go to DCUP on pulse_q=0.
  - PFDN (dclo=0, aclo=1): count PFDN_CLK, then go to OFF.
- Power loss (pwr_ok falls):
  - RUN goes to PFDN.
  - ACUP goes to PFDN with the counter reloaded.
  - DCUP, RWAIT and RHOLD go straight to OFF.
  - Power loss has priority over rst_req and over counter expiry in the same clock.
- Other rules:
  - Power restored during PFDN has no effect; the full power-down completes via OFF.
  - rst_req is ignored outside RUN.
  - A rising edge coincident with entry into RUN is ignored, because edge detection uses the previous-cycle rst_req registered in all states.
  - dclo and aclo are registered outputs, decoded from the next state, so they change in the same clock as the state.
  - The ordering invariant always holds: aclo=0 implies dclo=0.

Decomposition:
- Shared package: state enum (OFF, DCUP, ACUP, RUN, RWAIT, RHOLD, PFDN) and a clog2 function.
- One natural sub-module: dc_filt, the synchronizer plus glitch filter (parameter FLT_CLK; ports clk, reset, d, q).
- The FSM, counter and trigger logic stay in dc_psq.

Test Plan:
- Power-up: with small parameters (FLT=4, DCUP=10, ACUP=20, OFF=5), assert pwr_in at t0. Required: dclo falls exactly 2+4+10 clocks (plus one transition clock) after the OFF hold; aclo falls 20+1 clocks after dclo; run=1 alongside aclo=0.
- Glitch: pulse pwr_in for 3 clocks with FLT=4 → no state change. Hold it for 4 clocks → pwr_ok rises.
- Power fail from RUN: drop pwr_in. Required: aclo=1 after 2+4 clocks; dclo=1 exactly PFDN+1 clocks later; after OFF_CLK, re-power-up only if pwr_in is high.
- Restart: raise rst_req in RUN. Required: one clock of trig_a_n=0/trig_b=1; dclo=aclo=1 while dc_pulse q (width 50) is high; sequence resumes DCUP→ACUP→RUN. Holding rst_req high gives no second trigger.
- Timeout: tie pulse_q=0 and raise rst_req. Required: fault=1 after PTMO_CLK clocks and the FSM enters DCUP; fault clears on the next entry to OFF.
- Reset mid-ACUP: assert reset asynchronously. Required: dclo=aclo=1 and trig_b=0 immediately, without waiting for a clock edge; after release the FSM restarts from OFF.
